if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, sitting directly upstream of the decode stage. Owns the PC, issues one read per cycle to the synchronous instruction SRAM (fixed 1-cycle read latency) and presents `{pc, inst, valid}` to decode through the IF/ID pipeline register. Handles decode-stage back-pressure without losing in-flight data, branch redirects with MIPS delay-slot semantics, exception flushes and fetch-address-misalignment detection.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: PC loaded on reset.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inst_sram_en` out 1: read request this cycle.
- `inst_sram_addr` out 32: read address (current PC).
- `inst_sram_rdata` in 32: data for the request issued in the previous cycle.
- `id_stall` in 1: decode cannot accept; IF/ID register holds.
- `branch_taken` in 1: decode resolved a taken branch/jump; sampled only when `id_stall`=0.
- `branch_target` in 32: redirect PC, qualified by `branch_taken`.
- `flush` in 1: exception/eret flush from commit; highest priority.
- `flush_pc` in 32: PC to restart from on `flush`.
- `id_pc` out 32: PC of instruction presented to decode.
- `id_inst` out 32: instruction word to decode.
- `id_valid` out 1: `id_pc`/`id_inst` are meaningful.
- `id_adel` out 1: fetch address error (PC[1:0]≠0) for this entry.

## Operation
- State: `pc`, in-flight tag (`req_vld`, `req_pc`, `req_adel`), one-entry hold buffer (`hold_vld`, `hold_pc`, `hold_inst`, `hold_adel`), IF/ID register.
- Issue: when `id_stall`=0 and `hold_vld`=0, a request slot is issued: `req_vld`<=1, `req_pc`<=`pc`. `inst_sram_en`=1 only if `pc[1:0]`==0; misaligned PC issues no SRAM access but still creates an entry with `inst`=0, `adel`=1.
- Next PC, priority: `flush` → `flush_pc`; else `branch_taken` & !`id_stall` → `branch_target`; else issue → `pc`+4 (mod 2^32, wraps 0xFFFF_FFFC→0); else hold.
- Delay slot: the entry in flight or in hold when `branch_taken` is sampled is the delay slot and is delivered; only fetches after it come from `branch_target`.
- Return: in-flight data arriving while `id_stall`=1 is written to the hold buffer (`hold_vld`<=1). While `hold_vld`=1, no new request issues.
- IF/ID update when `id_stall`=0: source = hold buffer if `hold_vld`, else in-flight return if `req_vld`, else bubble (`id_valid`<=0). Consuming the hold entry clears `hold_vld`.
- `id_stall`=1: IF/ID register, `pc` unchanged; redirect inputs ignored.
- `flush`: same edge clears `req_vld`, `hold_vld`, `id_valid`, `id_adel`; `pc`<=`flush_pc`; SRAM data returning next cycle is discarded. Overrides `id_stall` and `branch_taken`.

## Timing
- Reset (async assert, sync use after deassert): `pc`=`RESET_PC`, `req_vld`=`hold_vld`=0, `id_valid`=0, `id_pc`=`RESET_PC`, `id_inst`=0, `id_adel`=0; `inst_sram_en`=1, `inst_sram_addr`=`RESET_PC` in first cycle after release.
- Latency: request in cycle N → `id_valid`=1 with that instruction in cycle N+2.
- Throughput: 1 instruction/cycle with no stall.
- Stall release: held instruction presented the cycle after `id_stall` drops; new request issued that same cycle, so at most one bubble after a stall of ≥1 cycle.
- Redirect: `branch_taken` in cycle N → `inst_sram_addr`=`branch_target` in N+1; target reaches decode in N+3.
- Flush in cycle N → `inst_sram_addr`=`flush_pc` in N+1, `id_valid`=0 in N+1 and N+2, first restart instruction valid in N+3.
- Reset mid-operation: all state returns to reset values immediately; no partial entry survives.

## Structure
- Shared pipeline package: `RESET_PC` default, `NOP_INST`=32'h0, IF/ID entry struct `{pc, inst, adel}`.
- One sub-module: `if_hold_buf` (single-entry skid register with load/consume/clear).

## Test plan
- Reset release, `rdata` = address-derived pattern: addresses BFC00000, BFC00004, … each cycle; `id_inst` matches, first `id_valid` 2 cycles after release.
- `id_stall`=1 for 3 cycles mid-stream: no instruction lost or duplicated; `id_pc` sequence strictly +4.
- `branch_taken`, target 0x8000_0100, at `id_pc`=BFC00010: BFC00014 (delay slot) delivered next, then 80000100.
- `flush` with `flush_pc`=0xBFC00380 during stall with `hold_vld`=1: hold discarded, two bubbles, then BFC00380.
- `flush_pc`=0x8000_0002: `inst_sram_en`=0, entry presented with `id_adel`=1, `id_inst`=0.
- `flush` and `branch_taken` same cycle: `flush_pc` wins; `branch_target` never fetched.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: reset vector, NOP word and
// the IF/ID entry layout handed from fetch to decode.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } if_id_entry_t;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_hold_buf.sv
// Single-entry skid register that catches an SRAM return while decode is stalled.
// Clear beats load, load beats consume.
module if_hold_buf
    import if_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         consume,
    input  logic         clear,
    input  if_id_entry_t load_entry,
    output logic         vld,
    output if_id_entry_t entry
);

    logic         vld_reg;
    if_id_entry_t entry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg   <= 1'b0;
            entry_reg <= '0;
        end else if (clear) begin
            vld_reg <= 1'b0;
        end else if (load) begin
            vld_reg   <= 1'b1;
            entry_reg <= load_entry;
        end else if (consume) begin
            vld_reg <= 1'b0;
        end
    end

    assign vld   = vld_reg;
    assign entry = entry_reg;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues one SRAM read per cycle and
// feeds decode through the IF/ID register with stall, delay-slot and flush handling.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    input  logic        id_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_adel
);

    logic [31:0]  pc_reg;
    logic [31:0]  pc_next;
    logic         req_vld_reg;
    logic [31:0]  req_pc_reg;
    logic         req_adel_reg;
    logic         id_valid_reg;
    if_id_entry_t id_reg;

    logic         hold_vld;
    if_id_entry_t hold_entry;
    logic         redirect;
    logic         issue;
    if_id_entry_t ret_entry;

    // An in-flight fetch at redirect time is the delay slot, so the fetch that
    // would issue behind it is dropped; with nothing in flight this issue is the slot.
    always_comb begin
        redirect  = branch_taken && !id_stall;
        issue     = !flush && !id_stall && !hold_vld && !(redirect && req_vld_reg);
        ret_entry = '{pc:   req_pc_reg,
                      inst: req_adel_reg ? NOP_INST : inst_sram_rdata,
                      adel: req_adel_reg};
        pc_next   = pc_reg;
        if (flush) begin
            pc_next = flush_pc;
        end else if (redirect) begin
            pc_next = branch_target;
        end else if (issue) begin
            pc_next = pc_reg + 32'd4;
        end
    end

    if_hold_buf u_hold_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (!flush && id_stall && req_vld_reg),
        .consume    (!flush && !id_stall && hold_vld),
        .clear      (flush),
        .load_entry (ret_entry),
        .vld        (hold_vld),
        .entry      (hold_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            req_vld_reg  <= 1'b0;
            req_pc_reg   <= RESET_PC;
            req_adel_reg <= 1'b0;
            id_valid_reg <= 1'b0;
            id_reg       <= '{pc: RESET_PC, inst: NOP_INST, adel: 1'b0};
        end else begin
            pc_reg <= pc_next;
            if (flush) begin
                req_vld_reg  <= 1'b0;
                id_valid_reg <= 1'b0;
                id_reg.adel  <= 1'b0;
            end else if (id_stall) begin
                // the returning word has moved into the hold buffer
                req_vld_reg <= 1'b0;
            end else begin
                req_vld_reg <= issue;
                if (issue) begin
                    req_pc_reg   <= pc_reg;
                    req_adel_reg <= pc_misaligned(pc_reg);
                end
                if (hold_vld) begin
                    id_reg       <= hold_entry;
                    id_valid_reg <= 1'b1;
                end else if (req_vld_reg) begin
                    id_reg       <= ret_entry;
                    id_valid_reg <= 1'b1;
                end else begin
                    id_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign inst_sram_en   = issue && !pc_misaligned(pc_reg);
    assign inst_sram_addr = pc_reg;
    assign id_pc          = id_reg.pc;
    assign id_inst        = id_reg.inst;
    assign id_adel        = id_reg.adel;
    assign id_valid       = id_valid_reg;

endmodule
